// File: rtl/mem_arbiter.sv
// Two-port arbiter serialising CPU (port 0) and secondary-master (port 1) accesses
// onto the single main-memory port, one transaction in flight, with a WAIT timeout.
package mem_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        access_type;
    logic [1:0]  access_size;
  } mem_cmd_t;
endpackage

module mem_arbiter #(
  parameter bit          FIXED_PRIORITY = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hdead_beef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_mem_access_0,
  input  logic [31:0] addr_0,
  input  logic [31:0] data_in_0,
  input  logic        access_type_0,
  input  logic [1:0]  access_size_0,
  output logic        wait_for_mem_0,
  output logic [31:0] data_out_0,
  input  logic        req_mem_access_1,
  input  logic [31:0] addr_1,
  input  logic [31:0] data_in_1,
  input  logic        access_type_1,
  input  logic [1:0]  access_size_1,
  output logic        wait_for_mem_1,
  output logic [31:0] data_out_1,
  output logic        mem_req_mem_access,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_access_type,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_in,
  input  logic        mem_wait_for_mem,
  output logic        grant,
  output logic        timeout_err
);
  import mem_arbiter_pkg::*;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  mem_cmd_t         cmd_q, cmd_d, cmd_0, cmd_1;
  logic             mem_req_q, mem_req_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic [31:0]      dout_0_q, dout_0_d, dout_1_q, dout_1_d;
  logic             winner;
  logic             finish;
  logic [31:0]      rdata;

  assign cmd_0 = {addr_0, data_in_0, access_type_0, access_size_0};
  assign cmd_1 = {addr_1, data_in_1, access_type_1, access_size_1};

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      mem_req_q    <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      terr_q       <= 1'b0;
      dout_0_q     <= '0;
      dout_1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      mem_req_q    <= mem_req_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      terr_q       <= terr_d;
      dout_0_q     <= dout_0_d;
      dout_1_q     <= dout_1_d;
    end
  end

  // Next state; the mem request pulse is set on entry to ISSUE so it is high during ISSUE
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    mem_req_d    = 1'b0;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    terr_d       = terr_q;
    dout_0_d     = dout_0_q;
    dout_1_d     = dout_1_q;
    winner       = 1'b0;
    finish       = 1'b0;
    rdata        = '0;
    case (state_q)
      IDLE: begin
        if (req_mem_access_0 || req_mem_access_1) begin
          if (req_mem_access_0 && req_mem_access_1)
            winner = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
          else
            winner = req_mem_access_1;
          cmd_d        = winner ? cmd_1 : cmd_0;
          grant_d      = winner;
          last_grant_d = winner;
          mem_req_d    = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!mem_wait_for_mem) begin
          rdata  = mem_data_in;
          finish = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata  = TIMEOUT_DATA;
          terr_d = 1'b1;
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (finish) begin
          state_d = DONE;
          if (grant_q) dout_1_d = rdata;
          else         dout_0_d = rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wait_for_mem_0 = req_mem_access_0 & ~((state_q == DONE) & ~grant_q);
  assign wait_for_mem_1 = req_mem_access_1 & ~((state_q == DONE) &  grant_q);

  assign data_out_0         = dout_0_q;
  assign data_out_1         = dout_1_q;
  assign mem_req_mem_access = mem_req_q;
  assign mem_addr           = cmd_q.addr;
  assign mem_data           = cmd_q.data;
  assign mem_access_type    = cmd_q.access_type;
  assign mem_access_size    = cmd_q.access_size;
  assign grant              = grant_q;
  assign timeout_err        = terr_q;

endmodule
